// File: rtl/tow_pkg.sv
// Shared types and LED constants for the tug-of-war match sequencer.
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PLAY,
        SHOW,
        DONE
    } state_t;

    localparam logic [6:0] LED_CENTER     = 7'b0001000;
    localparam logic [6:0] LED_RIGHT_END  = 7'b0000001;
    localparam logic [6:0] LED_LEFT_END   = 7'b1000000;
    localparam logic [6:0] LED_RIGHT_HALF = 7'b0000111;
    localparam logic [6:0] LED_LEFT_HALF  = 7'b1110000;

    function automatic logic [6:0] half_of(input logic right);
        return right ? LED_RIGHT_HALF : LED_LEFT_HALF;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Counts slowen ticks from a load point; done pulses on the tick that completes TICKS.
module tick_counter #(
    parameter int TICKS = 8,
    parameter int W     = $clog2(TICKS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = en && (count == W'(TICKS - 1));

endmodule

// File: rtl/match_ctrl.sv
// Best-of-N match sequencer beside mc; define MATCH_TIMEOUT_EN to end stalled games as draws.
module match_ctrl #(
    parameter int GAMES_TO_WIN  = 2,
    parameter int CNT_W         = 2,
    parameter int BLINK_TICKS   = 8,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slowen,
    input  logic [6:0]       score,
    input  logic             start,
    output logic             game_clr,
    output logic             play_en,
    output logic [CNT_W-1:0] wins_l,
    output logic [CNT_W-1:0] wins_r,
    output logic             match_over,
    output logic             match_winner,
    output logic             led_ovr_en,
    output logic [6:0]       led_ovr
);

    import tow_pkg::*;

    state_t     state;
    logic       side;
    logic       blink;
    logic       blink_done;
    logic       timeout_done;
    logic       right_win;
    logic       left_win;
    logic [CNT_W-1:0] winner_count;

    assign right_win    = (state == PLAY) && (score == LED_RIGHT_END);
    assign left_win     = (state == PLAY) && (score == LED_LEFT_END);
    assign winner_count = side ? wins_r : wins_l;

    tick_counter #(.TICKS(BLINK_TICKS)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .load (state != SHOW),
        .en   (slowen && (state == SHOW)),
        .done (blink_done)
    );

`ifdef MATCH_TIMEOUT_EN
    tick_counter #(.TICKS(TIMEOUT_TICKS)) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .load (state != PLAY),
        .en   (slowen && (state == PLAY)),
        .done (timeout_done)
    );
`else
    // TIMEOUT_TICKS is inert here; the expression is always false for legal values.
    assign timeout_done = (TIMEOUT_TICKS < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            side         <= 1'b0;
            blink        <= 1'b0;
            game_clr     <= 1'b0;
            play_en      <= 1'b0;
            wins_l       <= '0;
            wins_r       <= '0;
            match_over   <= 1'b0;
            match_winner <= 1'b0;
            led_ovr_en   <= 1'b0;
            led_ovr      <= '0;
        end else begin
            game_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        game_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= PLAY;
                    play_en <= 1'b1;
                end
                PLAY: begin
                    // A game win outranks a timeout expiring in the same cycle.
                    if (right_win || left_win) begin
                        side       <= right_win;
                        if (right_win && (wins_r != '1)) wins_r <= wins_r + 1'b1;
                        if (left_win && (wins_l != '1))  wins_l <= wins_l + 1'b1;
                        state      <= SHOW;
                        play_en    <= 1'b0;
                        blink      <= 1'b1;
                        led_ovr_en <= 1'b1;
                        led_ovr    <= half_of(right_win);
                    end else if (timeout_done) begin
                        state    <= CLEAR;
                        play_en  <= 1'b0;
                        game_clr <= 1'b1;
                    end
                end
                SHOW: begin
                    if (blink_done) begin
                        blink <= 1'b0;
                        if (winner_count == CNT_W'(GAMES_TO_WIN)) begin
                            state        <= DONE;
                            match_over   <= 1'b1;
                            match_winner <= side;
                            led_ovr      <= half_of(side);
                        end else begin
                            state      <= CLEAR;
                            game_clr   <= 1'b1;
                            led_ovr_en <= 1'b0;
                            led_ovr    <= '0;
                        end
                    end else if (slowen) begin
                        blink   <= ~blink;
                        led_ovr <= blink ? 7'b0 : half_of(side);
                    end
                end
                DONE: begin
                    if (start) begin
                        state        <= CLEAR;
                        game_clr     <= 1'b1;
                        wins_l       <= '0;
                        wins_r       <= '0;
                        match_over   <= 1'b0;
                        match_winner <= 1'b0;
                        led_ovr_en   <= 1'b0;
                        led_ovr      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized directed bench for match_ctrl with a game-level reference model.
module tb_match_ctrl;

    localparam int G  = 2;
    localparam int CW = 2;
    localparam int BT = 8;
    localparam int TT = 4;
    localparam logic [6:0] CTR   = 7'b0001000;
    localparam logic [6:0] END_R = 7'b0000001;
    localparam logic [6:0] END_L = 7'b1000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          slowen;
    logic          start;
    logic [6:0]    score;
    logic          game_clr;
    logic          play_en;
    logic [CW-1:0] wins_l;
    logic [CW-1:0] wins_r;
    logic          match_over;
    logic          match_winner;
    logic          led_ovr_en;
    logic [6:0]    led_ovr;

    int checks   = 0;
    int failures = 0;
    int exp_wins [2];
    bit decided;

    always #5 clk = ~clk;

    match_ctrl #(
        .GAMES_TO_WIN  (G),
        .CNT_W         (CW),
        .BLINK_TICKS   (BT),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .slowen       (slowen),
        .score        (score),
        .start        (start),
        .game_clr     (game_clr),
        .play_en      (play_en),
        .wins_l       (wins_l),
        .wins_r       (wins_r),
        .match_over   (match_over),
        .match_winner (match_winner),
        .led_ovr_en   (led_ovr_en),
        .led_ovr      (led_ovr)
    );

    function automatic logic [6:0] half(input bit right);
        return right ? 7'b0000111 : 7'b1110000;
    endfunction

    function automatic logic [6:0] distractor();
        logic [6:0] v;
        do v = 7'($urandom); while (v == END_R || v == END_L);
        return v;
    endfunction

    task automatic applyStimulus(input logic s_start, input logic s_slow, input logic [6:0] s_score);
        start  = s_start;
        slowen = s_slow;
        score  = s_score;
        @(posedge clk);
        #1;
        start  = 1'b0;
        slowen = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkWins(input string tag);
        checkOutput({tag, "_wins_l"}, 32'(wins_l), 32'(exp_wins[0]));
        checkOutput({tag, "_wins_r"}, 32'(wins_r), 32'(exp_wins[1]));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_game_clr"}, 32'(game_clr), 0);
        checkOutput({tag, "_play_en"}, 32'(play_en), 0);
        checkOutput({tag, "_wins_l"}, 32'(wins_l), 0);
        checkOutput({tag, "_wins_r"}, 32'(wins_r), 0);
        checkOutput({tag, "_match_over"}, 32'(match_over), 0);
        checkOutput({tag, "_match_winner"}, 32'(match_winner), 0);
        checkOutput({tag, "_led_ovr_en"}, 32'(led_ovr_en), 0);
        checkOutput({tag, "_led_ovr"}, 32'(led_ovr), 0);
    endtask

    // Plays one game from PLAY through its blink; leaves the bench in PLAY or DONE.
    task automatic playGame(input bit right, output bit done);
        int dwell;
        int slows;
        int ticks;
        int idle;
        bit s;
        logic [6:0] end_pos;
        end_pos = right ? END_R : END_L;
        dwell = $urandom_range(1, 12);
        slows = 0;
        for (int i = 0; i < dwell; i++) begin
            s = 1'($urandom_range(0, 1));
`ifdef MATCH_TIMEOUT_EN
            if (slows >= TT - 1) s = 1'b0;
`endif
            if (s) slows++;
            applyStimulus(1'($urandom_range(0, 1)), s, distractor());
            checkOutput("play_en_hold", 32'(play_en), 1);
            checkOutput("play_no_clr", 32'(game_clr), 0);
        end
        checkWins("pre_win");
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), end_pos);
        if (exp_wins[right] < (2 ** CW) - 1) exp_wins[right]++;
        checkWins("win");
        checkOutput("win_led_en", 32'(led_ovr_en), 1);
        checkOutput("win_led", 32'(led_ovr), 32'(half(right)));
        checkOutput("win_play_en", 32'(play_en), 0);
        ticks = 0;
        idle  = 0;
        while (ticks < BT) begin
            s = (idle >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            idle = s ? 0 : idle + 1;
            applyStimulus(1'($urandom_range(0, 1)), s, end_pos);
            if (s) ticks++;
            if (ticks < BT) begin
                checkOutput("blink_en", 32'(led_ovr_en), 1);
                checkOutput("blink_pat", 32'(led_ovr), (ticks % 2 == 0) ? 32'(half(right)) : 0);
                checkOutput("blink_no_clr", 32'(game_clr), 0);
            end
        end
        done = (exp_wins[right] == G);
        if (done) begin
            checkOutput("done_over", 32'(match_over), 1);
            checkOutput("done_winner", 32'(match_winner), 32'(right));
            checkOutput("done_led_en", 32'(led_ovr_en), 1);
            checkOutput("done_led", 32'(led_ovr), 32'(half(right)));
            checkOutput("done_no_clr", 32'(game_clr), 0);
        end else begin
            checkOutput("next_clr", 32'(game_clr), 1);
            checkOutput("next_led_en", 32'(led_ovr_en), 0);
            checkOutput("next_over", 32'(match_over), 0);
            applyStimulus(1'b0, 1'b0, CTR);
            checkOutput("next_play_en", 32'(play_en), 1);
            checkOutput("next_clr_off", 32'(game_clr), 0);
        end
    endtask

    // Holds DONE for a while, then restarts and checks the cleared match.
    task automatic restartMatch(input bit right);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), distractor());
            checkOutput("hold_over", 32'(match_over), 1);
            checkOutput("hold_led", 32'(led_ovr), 32'(half(right)));
        end
        applyStimulus(1'b1, 1'b0, CTR);
        exp_wins[0] = 0;
        exp_wins[1] = 0;
        checkWins("restart");
        checkOutput("restart_clr", 32'(game_clr), 1);
        checkOutput("restart_over", 32'(match_over), 0);
        checkOutput("restart_led_en", 32'(led_ovr_en), 0);
        applyStimulus(1'b0, 1'b0, CTR);
        checkOutput("restart_play_en", 32'(play_en), 1);
        checkOutput("restart_clr_off", 32'(game_clr), 0);
    endtask

    initial begin
        bit side;
        rst    = 1'b1;
        start  = 1'b0;
        slowen = 1'b0;
        score  = CTR;
        exp_wins[0] = 0;
        exp_wins[1] = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        applyStimulus(1'b0, 1'b1, CTR);
        checkOutput("idle_no_clr", 32'(game_clr), 0);
        applyStimulus(1'b1, 1'b0, CTR);
        checkOutput("start_clr", 32'(game_clr), 1);
        checkOutput("start_play_en", 32'(play_en), 0);
        applyStimulus(1'b0, 1'b0, CTR);
        checkOutput("first_clr_off", 32'(game_clr), 0);
        checkOutput("first_play_en", 32'(play_en), 1);
        checkOutput("first_led_en", 32'(led_ovr_en), 0);
        checkWins("first");

        playGame(1'b1, decided);
        checkOutput("after_g1_undecided", 32'(decided), 0);
        playGame(1'b1, decided);
        checkOutput("after_g2_decided", 32'(decided), 1);
        restartMatch(1'b1);

        decided = 1'b0;
        side    = 1'b0;
        for (int g = 0; g < 2 * G - 1 && !decided; g++) begin
            side = 1'($urandom_range(0, 1));
            playGame(side, decided);
        end
        checkOutput("random_match_decided", 32'(decided), 1);
        restartMatch(side);

`ifndef MATCH_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? CTR : 7'b0000011);
            if (i % 25 == 24) begin
                checkOutput("stall_play_en", 32'(play_en), 1);
                checkOutput("stall_no_clr", 32'(game_clr), 0);
                checkWins("stall");
            end
        end
        applyStimulus(1'b0, 1'b0, END_L);
        exp_wins[0]++;
        checkWins("pre_reset_win");
        checkOutput("pre_reset_led_en", 32'(led_ovr_en), 1);
`else
        for (int i = 0; i < TT - 1; i++) begin
            applyStimulus(1'b0, 1'b1, CTR);
            checkOutput("to_play_en", 32'(play_en), 1);
            checkOutput("to_no_clr", 32'(game_clr), 0);
        end
        applyStimulus(1'b0, 1'b1, CTR);
        checkOutput("to_expire_clr", 32'(game_clr), 1);
        checkOutput("to_expire_led_en", 32'(led_ovr_en), 0);
        checkWins("to_expire");
        applyStimulus(1'b0, 1'b0, CTR);
        checkOutput("to_replay_en", 32'(play_en), 1);
        for (int i = 0; i < TT - 1; i++) applyStimulus(1'b0, 1'b1, CTR);
        applyStimulus(1'b0, 1'b1, END_R);
        exp_wins[1]++;
        checkWins("to_coincident_win");
        checkOutput("to_coincident_no_clr", 32'(game_clr), 0);
        checkOutput("to_coincident_led_en", 32'(led_ovr_en), 1);
`endif

        applyStimulus(1'b0, 1'b1, score);
        applyStimulus(1'b0, 1'b1, score);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, score);
        rst = 1'b0;
        exp_wins[0] = 0;
        exp_wins[1] = 0;
        checkAllZero("mid_show_reset");

        applyStimulus(1'b1, 1'b0, CTR);
        applyStimulus(1'b0, 1'b0, CTR);
        applyStimulus(1'b1, 1'b0, CTR);
        checkOutput("play_start_ignored_clr", 32'(game_clr), 0);
        checkOutput("play_start_ignored_en", 32'(play_en), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
